data_mem_seq: RTL and testbench
===============================

DATA_MEM_SEQ -- requirements
Module: data_mem_seq

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 E  in  1  memory-stage access enable from control unit.
REQ-004 RW  in  1  1=store, 0=load.
REQ-005 SIZE  in  2  00=byte, 01=halfword, 10=word, 11=reserved.
REQ-006 SE  in  1  sign-extend load result (byte/halfword only).
REQ-007 addr  in  32  byte address of the access.
REQ-008 wdata  in  32  store data, right-justified.
REQ-009 rdata  out  32  extended load result, valid while done=1.
REQ-010 stall  out  1  freeze pipeline stages upstream of and including MEM.
REQ-011 done  out  1  one-cycle pulse when access completes.
REQ-012 mem_req  out  1  byte-port request.
REQ-013 mem_we  out  1  byte-port write strobe.
REQ-014 mem_addr  out  32  byte-port address.
REQ-015 mem_wdata  out  8  byte-port write data.
REQ-016 mem_rdata  in  8  byte-port read data, valid when mem_ack=1.
REQ-017 mem_ack  in  1  beat completes on any cycle with mem_req=1 and mem_ack=1.
REQ-018 align_err  out  1  one-cycle pulse on misaligned access (DMS_ALIGN_CHECK_EN only; tied 0 otherwise).

Function
REQ-019 FSM states IDLE, ACCESS, DONE; request captured (RW, SIZE, SE, addr, wdata) in IDLE when E=1.
REQ-020 Beat count: byte 1, halfword 2, word 4; SIZE=11 treated as word.
REQ-021 Big-endian: beat k uses mem_addr=addr+k; beat 0 carries most-significant byte.
REQ-022 Store beat k drives mem_wdata = byte (n-1-k) of the right-justified wdata, where n is the beat count.
REQ-023 Load beats shift mem_rdata into an accumulator; in DONE, rdata = zero-extension, or sign-extension when SE=1 and SIZE is byte/halfword.
REQ-024 In ACCESS, mem_req=1 and mem_we=captured RW; mem_addr/mem_wdata stable until ack; beat counter advances only on ack.
REQ-025 Last beat acked -> DONE; DONE lasts exactly one cycle (done=1, stall=0) -> IDLE.
REQ-026 stall = (state==IDLE and E=1) or state==ACCESS; stall=0 in DONE.
REQ-027 Minimum latency with ack always high: byte 3, halfword 4, word 6 cycles from E to done; stall high for 2/3/5 cycles.
REQ-028 E sampled in the cycle after DONE starts a new access (back-to-back accesses allowed, no idle gap required).
REQ-029 Changes on E/addr/wdata while in ACCESS are ignored.
REQ-030 mem_req=0 in IDLE and DONE; rdata holds last value outside DONE.

Reset
REQ-031 Reset: state IDLE; beat counter, accumulator, rdata = 0; done, mem_req, mem_we, align_err = 0; mem_addr, mem_wdata = 0.
REQ-032 Reset during ACCESS aborts the access with no done pulse; mem_req=0 from the following cycle.

Configuration
REQ-033 DMS_ALIGN_CHECK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 issues no beats, IDLE->DONE directly with align_err=1, done=1, rdata=0.
REQ-034 DMS_ALIGN_CHECK_EN undefined: no check; misaligned accesses run as normal sequential beats from addr; align_err tied 0.

Structure
REQ-035 Shared package dms_pkg holds the state enum, SIZE encodings (BYTE, HALF, WORD), and the beat-count function.
REQ-036 Sub-module dms_load_ext (combinational: accumulator, SIZE, SE -> rdata) is instantiated once.

Verification
REQ-037 ldub, addr=0x100, mem byte 0x80, ack always 1 -> done at cycle 3, rdata=0x00000080, stall 2 cycles.
REQ-038 ldsh, addr=0x202, bytes 0xFF,0x7E -> mem_addr 0x202, 0x203; rdata=0xFFFFFF7E.
REQ-039 st word 0x11223344 at 0x300, ack delayed 2 cycles per beat -> writes 0x11,0x22,0x33,0x44 to 0x300..0x303; mem_addr/mem_wdata stable while waiting; stall held until DONE.
REQ-040 Back-to-back stb 0xAB at 0x10 then ld at 0x20 -> second capture in the cycle after done; no lost or duplicated beat.
REQ-041 rst asserted during the 3rd beat of a word load -> next cycle IDLE, mem_req=0, no done pulse.
REQ-042 With DMS_ALIGN_CHECK_EN: ld at 0x102 -> no mem_req, align_err=1 and done=1 in the same cycle, rdata=0; without the macro, 4 beats at 0x102..0x105.

Source files
------------

// File: rtl/dms_pkg.sv
// Shared definitions for the sequential byte-port data memory adapter:
// FSM states, SIZE encodings, captured-request record and beat helpers.
package dms_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 behaves as a word

  // Request fields frozen at the IDLE->busy transition.
  typedef struct packed {
    logic        rw;
    logic [1:0]  size;
    logic        se;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Number of byte-port beats an access of the given size needs.
  function automatic logic [2:0] beat_count(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Natural-alignment test on the two low address bits.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dms_load_ext.sv
// Load result extension: picks the low byte/halfword/word of the
// big-endian accumulator and zero- or sign-extends it to 32 bits.
module dms_load_ext
  import dms_pkg::*;
(
  input  logic [31:0] acc_i,
  input  logic [1:0]  size_i,
  input  logic        se_i,
  output logic [31:0] rdata_o
);

  // Width selection and extension; word loads ignore SE.
  always_comb begin
    rdata_o = acc_i;
    case (size_i)
      SZ_BYTE: rdata_o = {{24{se_i & acc_i[7]}}, acc_i[7:0]};
      SZ_HALF: rdata_o = {{16{se_i & acc_i[15]}}, acc_i[15:0]};
      default: rdata_o = acc_i;
    endcase
  end

endmodule

// File: rtl/data_mem_seq.sv
// Sequential data-memory adapter: turns one byte/halfword/word load or
// store from the MEM stage into 1/2/4 big-endian beats on an 8-bit
// request/ack port, stalling the pipeline until the access completes.
// Optional build macro DMS_ALIGN_CHECK_EN: misaligned halfword/word
// accesses skip the port and finish immediately with align_err=1.
module data_mem_seq
  import dms_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        E,
  input  logic        RW,
  input  logic [1:0]  SIZE,
  input  logic        SE,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        align_err
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ext_rdata;
  logic [2:0]  n_beats;
  logic [1:0]  last_idx;
  logic [1:0]  byte_sel;
`ifdef DMS_ALIGN_CHECK_EN
  logic        err_q, err_d;
`endif

  // Index of the final beat: 1/2/4 minus one, computed in two bits so
  // that 4 (3'b100) wraps naturally to 2'b11.
  assign n_beats  = beat_count(req_q.size);
  assign last_idx = n_beats[1:0] - 2'd1;
  // Beat k of a store carries byte (n-1-k) of the right-justified data.
  assign byte_sel = last_idx - cnt_q;

  dms_load_ext u_load_ext (
    .acc_i   (acc_q),
    .size_i  (req_q.size),
    .se_i    (req_q.se),
    .rdata_o (ext_rdata)
  );

  // Next-state logic: capture in IDLE, count acked beats in ACCESS,
  // latch the extended result in the single DONE cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rdata_d = rdata_q;
`ifdef DMS_ALIGN_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (E) begin
          req_d   = '{rw: RW, size: SIZE, se: SE, addr: addr, wdata: wdata};
          cnt_d   = 2'd0;
          acc_d   = 32'd0;
          state_d = ST_ACCESS;
`ifdef DMS_ALIGN_CHECK_EN
          err_d   = misaligned(SIZE, addr[1:0]);
          if (err_d) state_d = ST_DONE;
`endif
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          if (!req_q.rw) acc_d = {acc_q[23:0], mem_rdata};
          if (cnt_q == last_idx) state_d = ST_DONE;
          else                   cnt_d   = cnt_q + 2'd1;
        end
      end
      ST_DONE: begin
        rdata_d = ext_rdata;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= 2'd0;
      acc_q   <= 32'd0;
      rdata_q <= 32'd0;
`ifdef DMS_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
`ifdef DMS_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Port and pipeline outputs decoded from the registered state.
  always_comb begin
    stall     = (state_q == ST_ACCESS) || ((state_q == ST_IDLE) && E);
    done      = (state_q == ST_DONE);
    mem_req   = (state_q == ST_ACCESS);
    mem_we    = (state_q == ST_ACCESS) && req_q.rw;
    mem_addr  = 32'd0;
    mem_wdata = 8'd0;
    rdata     = (state_q == ST_DONE) ? ext_rdata : rdata_q;
    if (state_q == ST_ACCESS) begin
      mem_addr = req_q.addr + {30'd0, cnt_q};
      case (byte_sel)
        2'd0:    mem_wdata = req_q.wdata[7:0];
        2'd1:    mem_wdata = req_q.wdata[15:8];
        2'd2:    mem_wdata = req_q.wdata[23:16];
        default: mem_wdata = req_q.wdata[31:24];
      endcase
    end
  end

`ifdef DMS_ALIGN_CHECK_EN
  assign align_err = (state_q == ST_DONE) && err_q;
`else
  assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_seq.sv
// Self-checking bench for data_mem_seq: directed scenarios followed by
// randomized load/store traffic with random ack delays, checked against
// a byte-addressed memory model and arithmetic extension rules.
module tb_data_mem_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        E, RW, SE;
  logic [1:0]  SIZE;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, done, mem_req, mem_we, align_err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem_model [logic [31:0]];
  logic [31:0] last_rd;
  bit          last_valid;

  data_mem_seq dut (
    .clk       (clk),
    .rst       (rst),
    .E         (E),
    .RW        (RW),
    .SIZE      (SIZE),
    .SE        (SE),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .done      (done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .align_err (align_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (!mem_model.exists(a)) mem_model[a] = 8'($urandom);
    return mem_model[a];
  endfunction

  // Load result from the raw big-endian bytes using plain arithmetic.
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic se);
    longint mask, val;
    mask = (size == 2'b00) ? 64'hFF : (size == 2'b01) ? 64'hFFFF : 64'hFFFF_FFFF;
    val  = longint'(raw) & mask;
    if (se && size[1] == 1'b0 && val > (mask >> 1)) val = val - (mask + 1);
    return 32'(val);
  endfunction

  // One complete access from the E cycle through the DONE cycle.
  task automatic access(input logic rw, input logic [1:0] size, input logic se,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int dmin, input int dmax);
    int          n;
    logic [31:0] raw, exp_rd;
    logic [7:0]  b;
    bit          mis;
    n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    mis = 1'b0;
`ifdef DMS_ALIGN_CHECK_EN
    mis = (size == 2'b01 && a[0]) || (size[1] && a[1:0] != 2'b00);
`endif
    raw = 32'd0;
    @(negedge clk);
    E = 1'b1; RW = rw; SIZE = size; SE = se; addr = a; wdata = wd; mem_ack = 1'b0;
    #1;
    check("cap_stall", stall, 1);
    check("cap_req", mem_req, 0);
    check("cap_done", done, 0);
    if (!mis) begin
      for (int k = 0; k < n; k++) begin
        int d;
        d = $urandom_range(dmax, dmin);
        for (int w = 0; w <= d; w++) begin
          @(negedge clk);
          E = 1'($urandom); addr = $urandom; wdata = $urandom;
          mem_ack = (w == d);
          b = (w == d && !rw) ? rd_byte(a + k) : 8'($urandom);
          mem_rdata = b;
          #1;
          check("acc_req", mem_req, 1);
          check("acc_we", mem_we, rw);
          check("acc_addr", mem_addr, a + k);
          if (rw) check("acc_wdata", mem_wdata, (wd >> (8 * (n - 1 - k))) & 32'hFF);
          check("acc_stall", stall, 1);
          check("acc_done", done, 0);
        end
        if (rw) mem_model[a + k] = 8'((wd >> (8 * (n - 1 - k))) & 32'hFF);
        else    raw = (raw << 8) | {24'd0, b};
      end
    end
    @(negedge clk);
    E = 1'b0; mem_ack = 1'b0;
    #1;
    check("done_pulse", done, 1);
    check("done_stall", stall, 0);
    check("done_req", mem_req, 0);
    check("done_align", align_err, mis);
    exp_rd = mis ? 32'd0 : extend(raw, size, se);
    if (!rw || mis) begin
      check("done_rdata", rdata, exp_rd);
      last_rd = exp_rd; last_valid = 1'b1;
    end else begin
      last_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      E = 1'b0; mem_ack = 1'b0; addr = $urandom;
      #1;
      check("idle_req", mem_req, 0);
      check("idle_stall", stall, 0);
      check("idle_done", done, 0);
      if (last_valid) check("idle_rdata_hold", rdata, last_rd);
    end
  endtask

  // Word load aborted by reset while its third beat is pending.
  task automatic reset_abort(input logic [31:0] a);
    @(negedge clk);
    E = 1'b1; RW = 1'b0; SIZE = 2'b10; SE = 1'b0; addr = a; mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      E = 1'b0; mem_ack = (k < 2); mem_rdata = rd_byte(a + k);
      if (k == 2) rst = 1'b1;
      #1;
      check("abort_addr", mem_addr, a + k);
      check("abort_req", mem_req, 1);
    end
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b0;
    #1;
    check("abort_req_off", mem_req, 0);
    check("abort_no_done", done, 0);
    check("abort_stall", stall, 0);
    check("abort_rdata", rdata, 0);
    last_rd = 32'd0; last_valid = 1'b1;
    idle(2);
  endtask

  initial begin
    rst = 1'b1; E = 1'b0; RW = 1'b0; SIZE = 2'b00; SE = 1'b0;
    addr = 32'd0; wdata = 32'd0; mem_rdata = 8'd0; mem_ack = 1'b0;
    last_rd = 32'd0; last_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_done", done, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_mwdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_stall", stall, 0);
    check("rst_align", align_err, 0);

    // Unsigned byte load, ack always high.
    mem_model[32'h100] = 8'h80;
    access(1'b0, 2'b00, 1'b0, 32'h100, 32'd0, 0, 0);
    check("ldub_value", last_rd, 32'h0000_0080);
    idle(1);

    // Signed halfword load.
    mem_model[32'h202] = 8'hFF;
    mem_model[32'h203] = 8'h7E;
    access(1'b0, 2'b01, 1'b1, 32'h202, 32'd0, 0, 0);
    check("ldsh_value", last_rd, 32'hFFFF_FF7E);
    idle(1);

    // Word store with two wait cycles per beat, then read back.
    access(1'b1, 2'b10, 1'b0, 32'h300, 32'h1122_3344, 2, 2);
    check("stw_b0", mem_model[32'h300], 8'h11);
    check("stw_b3", mem_model[32'h303], 8'h44);
    access(1'b0, 2'b10, 1'b0, 32'h300, 32'd0, 0, 1);

    // Back-to-back: byte store then word load with no idle gap.
    access(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_00AB, 0, 0);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 0, 0);
    access(1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 0, 0);
    check("b2b_readback", last_rd, 32'h0000_00AB);
    idle(1);

    // Reset during the third beat of a word load.
    reset_abort(32'h400);

    // Misaligned word load at 0x102.
    access(1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 0, 0);
    idle(1);

    // Randomized traffic over a small window so loads see earlier stores.
    for (int i = 0; i < 150; i++) begin
      access(1'($urandom), 2'($urandom_range(3, 0)), 1'($urandom),
             32'h1000 + 32'($urandom_range(31, 0)), $urandom, 0, 2);
      idle($urandom_range(2, 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
